adder_pipe: RTL

//  Parametrised, pipelined successor to the team's combinational adder.

---
 rtl/adder_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/adder_pipe.sv
// ============================================================================
// adder_pipe : WIDTH-bit adder split into STAGES carry-chained chunks,
//              one chunk per clock, with valid/ready flow control.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Stage k keeps only the bits later stages still need: the finished low sum
  // chunks, and the operand chunks above its own.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * CW;
    localparam int HI  = (k + 1) * CW;

    logic           v_src;
    logic           c_src;
    logic           sm_src;
    logic [REM-1:0] a_src;
    logic [REM-1:0] b_src;
    logic [CW:0]    add_w;
    logic [HI-1:0]  sum_d;
    logic [HI-1:0]  sum_q;
    logic           v_q;
    logic           c_q;

    if (k == 0) begin : g_head
      assign v_src  = in_valid;
      assign c_src  = cin;
      assign sm_src = signed_mode;
      assign a_src  = a;
      assign b_src  = b;
      assign sum_d  = add_w[CW-1:0];
    end else begin : g_body
      assign v_src  = g_stage[k-1].v_q;
      assign c_src  = g_stage[k-1].c_q;
      assign sm_src = g_stage[k-1].g_fwd.sm_q;
      assign a_src  = g_stage[k-1].g_fwd.a_q;
      assign b_src  = g_stage[k-1].g_fwd.b_q;
      assign sum_d  = {add_w[CW-1:0], g_stage[k-1].sum_q};
    end

    assign add_w = {1'b0, a_src[CW-1:0]} + {1'b0, b_src[CW-1:0]} + {{CW{1'b0}}, c_src};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_src;
        c_q   <= add_w[CW];
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CW-1:0] a_q;
      logic [REM-CW-1:0] b_q;
      logic              sm_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          b_q  <= '0;
          sm_q <= 1'b0;
        end else if (en) begin
          a_q  <= a_src[REM-1:CW];
          b_q  <= b_src[REM-1:CW];
          sm_q <= sm_src;
        end
      end
    end else begin : g_tail
      logic ovf_d;
      logic ovf_q;

      // Here a_src/b_src hold only the top chunk, so bit CW-1 is the operand MSB.
      assign ovf_d = sm_src ? ((a_src[CW-1] == b_src[CW-1]) & (sum_d[WIDTH-1] != a_src[CW-1]))
                            : add_w[CW];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

`default_nettype wire
